// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: fetch-PC counter, single-outstanding imem request port
// and a DEPTH-entry prefetch queue feeding the IF/ID register, with delay-slot aware redirects.
module if_prefetch_queue #(
    parameter int          ADDR_W   = 9,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    input  logic              redirect_keep,
    output logic [31:0]       fetch_pc,
    output logic [1:0]        dbg_state
);
    // Handshakes: the queue head pops on every edge where inst_valid && inst_ready (inst_valid never
    // depends on inst_ready); imem_req is always accepted and its response returns with imem_rvalid.

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_wr;
    logic [ADDR_W-1:0] r_fpc;
    logic [ADDR_W-1:0] r_req_pc;
    logic [ADDR_W-1:0] r_tgt_q;
    logic              r_slot_pending;
    logic [31:0]       r_inst_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];

    logic              w_valid;
    logic              w_pop;
    logic [CNT_W-1:0]  w_cnt_after_pop;
    logic              w_empty_after_pop;
    logic [CNT_W-1:0]  w_occ;
    logic              w_room;
    logic              w_issue;
    logic              w_push;
    logic              w_slot_inflight;
    logic              w_slot_later;
    logic              w_keep_head;
    logic              w_flush_all;
    logic [ADDR_W-1:0] w_target;
    logic              w_unused_tgt;

    assign w_valid           = (r_count != '0);
    assign w_pop             = w_valid & inst_ready;
    assign w_cnt_after_pop   = r_count - CNT_W'(w_pop);
    assign w_empty_after_pop = (w_cnt_after_pop == '0);
    assign w_occ             = r_count + CNT_W'(r_state != S_IDLE);
    assign w_room            = (w_occ < CNT_W'(DEPTH)) | ((w_occ == CNT_W'(DEPTH)) & w_pop);
    assign w_issue           = ~reset & ~redirect_valid & w_room
                               & ((r_state == S_IDLE) | imem_rvalid);
    assign w_target          = {redirect_target[ADDR_W-1:2], 2'b00};
    assign w_unused_tgt      = &{1'b0, redirect_target[31:ADDR_W], redirect_target[1:0]};

    // Delay slot already in flight (WAIT) versus not yet fetched (slot_pending path).
    assign w_slot_inflight = redirect_valid & redirect_keep & w_empty_after_pop & (r_state == S_WAIT);
    assign w_slot_later    = redirect_valid & redirect_keep & w_empty_after_pop & (r_state != S_WAIT);
    assign w_keep_head     = redirect_valid & redirect_keep & ~w_empty_after_pop;
    assign w_flush_all     = redirect_valid & ~redirect_keep;
    assign w_push          = imem_rvalid & (r_state == S_WAIT) & (~redirect_valid | w_slot_inflight);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_rd           <= '0;
            r_wr           <= '0;
            r_fpc          <= L_RESET_PC;
            r_req_pc       <= '0;
            r_tgt_q        <= '0;
            r_slot_pending <= 1'b0;
        end else begin
            if (redirect_valid) begin
                if (imem_rvalid || r_state == S_IDLE) begin
                    r_state <= S_IDLE;
                end else if (w_slot_inflight) begin
                    r_state <= S_WAIT;
                end else begin
                    r_state <= S_DROP;
                end
            end else if (w_issue) begin
                r_state <= S_WAIT;
            end else if (imem_rvalid) begin
                r_state <= S_IDLE;
            end

            if (w_flush_all) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else if (w_keep_head) begin
                r_rd    <= r_rd + PTR_W'(w_pop);
                r_wr    <= r_rd + PTR_W'(w_pop) + PTR_W'(1);
                r_count <= CNT_W'(1);
            end else begin
                if (w_push) r_wr <= r_wr + PTR_W'(1);
                if (w_pop)  r_rd <= r_rd + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end

            if (redirect_valid) begin
                if (w_slot_later) begin
                    r_tgt_q        <= w_target;
                    r_slot_pending <= 1'b1;
                end else begin
                    r_fpc          <= w_target;
                    r_slot_pending <= 1'b0;
                end
            end else if (w_issue) begin
                r_req_pc       <= r_fpc;
                r_fpc          <= r_slot_pending ? r_tgt_q : r_fpc + ADDR_W'(4);
                r_slot_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr] <= imem_rdata;
            r_pc_mem[r_wr]   <= r_req_pc;
        end
    end

    assign imem_req   = w_issue;
    assign imem_addr  = r_fpc;
    assign inst_valid = w_valid;
    assign inst       = w_valid ? r_inst_mem[r_rd] : '0;
    assign inst_pc    = w_valid ? 32'(r_pc_mem[r_rd]) : '0;
    assign fetch_pc   = 32'(r_fpc);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: variable-latency memory model, expected-PC
// scoreboard popped on every head consume, and directed redirect/wrap/reset scenarios.
module tb_if_prefetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        redirect_keep = 1'b0;
    logic [31:0] fetch_pc;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int due_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] req_log[$];
    logic [31:0] exp_q[$];

    if_prefetch_queue #(.ADDR_W(9), .DEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .redirect_keep(redirect_keep), .fetch_pc(fetch_pc), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA500_0007 ^ (a << 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // memory model: request seen in cycle k answers with rvalid in cycle k+mem_lat
    always @(negedge clk) begin
        if (imem_req) begin
            due_q.push_back(cyc + mem_lat);
            addr_q.push_back(32'(imem_addr));
            req_log.push_back(32'(imem_addr));
        end
    end

    always begin
        @(posedge clk);
        cyc++;
        #1;
        imem_rvalid = 1'b0;
        while (due_q.size() != 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end
        if (due_q.size() != 0 && due_q[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(addr_q.pop_front());
            void'(due_q.pop_front());
        end
    end

    // one cycle: scoreboard at the negedge, return 1 time unit after the next posedge
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        if (!reset && inst_valid && inst_ready) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("sb_pc", inst_pc, e);
            chk("sb_inst", inst, mem_word(e));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_empty(input int budget, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        inst_ready = 1'b0;
    endtask

    task automatic do_reset(input int lat);
        reset = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_keep = 1'b0;
        mem_lat = lat;
        repeat (3) step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_fpc", fetch_pc, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        req_log.delete();
        #1;
    endtask

    initial begin
        int n;

        // sequential fetch, latency 1
        do_reset(1);
        inst_ready = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
        chk("a_c0_req", 32'(imem_req), 32'd1);
        chk("a_c0_addr", 32'(imem_addr), 32'd0);
        step();
        chk("a_c1_valid", 32'(inst_valid), 32'd0);
        step();
        chk("a_c2_valid", 32'(inst_valid), 32'd1);
        run_until_empty(20, n);
        chk("a_back_to_back", 32'(n), 32'd7);

        // back-pressure fills exactly DEPTH entries, then drains
        do_reset(1);
        repeat (10) step();
        chk("b_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("b_req_addr", req_log[i], 32'(i * 4));
        chk("b_req_stopped", 32'(imem_req), 32'd0);
        chk("b_full_head", inst_pc, 32'd0);
        inst_ready = 1'b1;
        #1;
        chk("b_pop_issue", 32'(imem_req), 32'd1);
        chk("b_pop_addr", 32'(imem_addr), 32'd16);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        run_until_empty(20, n);
        chk("b_drain_cycles", 32'(n), 32'd6);

        // keep=1 with queue {8,12,16} and ready low: 8 is the delay slot
        do_reset(1);
        repeat (8) step();
        inst_ready = 1'b1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        step();
        step();
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_keep = 1'b1;
        redirect_target = 32'h40;
        exp_q.push_back(32'd8);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        #1;
        chk("c_redir_no_req", 32'(imem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("c_tgt_req", 32'(imem_req), 32'd1);
        chk("c_tgt_addr", 32'(imem_addr), 32'h40);
        run_until_empty(20, n);

        // keep=0 flushes a full queue; the word popped in the same cycle survives
        do_reset(1);
        repeat (8) step();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_keep = 1'b0;
        redirect_target = 32'h60;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h60);
        exp_q.push_back(32'h64);
        step();
        redirect_valid = 1'b0;
        run_until_empty(20, n);

        // latency 3, keep=0 while WAIT: outstanding word is dropped
        do_reset(3);
        inst_ready = 1'b1;
        exp_q.push_back(32'd0);
        repeat (5) step();
        chk("d_wait", 32'(dbg_state), 32'd1);
        redirect_valid = 1'b1;
        redirect_keep = 1'b0;
        redirect_target = 32'h100;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("d_drop", 32'(dbg_state), 32'd2);
        chk("d_tgt_req", 32'(imem_req), 32'd1);
        chk("d_tgt_addr", 32'(imem_addr), 32'h100);
        run_until_empty(40, n);
        chk("d_req1", req_log[1], 32'd4);
        chk("d_req2", req_log[2], 32'h100);

        // IDLE + empty + keep=1: delay slot fetched from fpc, then target
        do_reset(1);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_keep = 1'b0;
        redirect_target = 32'h20;
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h84);
        #1;
        chk("e_no_req0", 32'(imem_req), 32'd0);
        step();
        redirect_keep = 1'b1;
        redirect_target = 32'h80;
        #1;
        chk("e_no_req1", 32'(imem_req), 32'd0);
        chk("e_fpc", fetch_pc, 32'h20);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("e_slot_addr", 32'(imem_addr), 32'h20);
        step();
        chk("e_tgt_addr", 32'(imem_addr), 32'h80);
        run_until_empty(20, n);
        chk("e_req0", req_log[0], 32'h20);
        chk("e_req1", req_log[1], 32'h80);

        // fetch PC wraps at 2^ADDR_W; target upper and low bits ignored
        do_reset(1);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_keep = 1'b0;
        redirect_target = 32'hABCD_FFFF;
        exp_q.push_back(32'h1FC);
        exp_q.push_back(32'h000);
        exp_q.push_back(32'h004);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("f_fpc_1fc", fetch_pc, 32'h1FC);
        chk("f_addr_1fc", 32'(imem_addr), 32'h1FC);
        step();
        chk("f_fpc_wrap", fetch_pc, 32'h000);
        run_until_empty(20, n);

        // reset while WAIT: the late response is ignored, fetch restarts at RESET_PC
        do_reset(3);
        inst_ready = 1'b1;
        repeat (4) step();
        chk("g_wait", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        repeat (3) step();
        chk("g_rst_valid", 32'(inst_valid), 32'd0);
        reset = 1'b0;
        req_log.delete();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        run_until_empty(40, n);
        chk("g_first_req", req_log[0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
